rep_mem_write_sched: RTL and testbench
======================================

# rep_mem_write_sched

Write-port scheduler for the 1-write/32-read replicated-read memory. Shares the single write port (w1_addr, w1_din, en_w1) among NREQ requesters with round-robin arbitration, and clears the whole memory to zero after reset or on command by sweeping every address. It sits directly in front of the memory's write port. The read ports are untouched and connect straight to the memory.

## Interface
- BLOCKSIZE, 10: address MSB index; addresses are BLOCKSIZE+1 bits; DEPTH = 2<<BLOCKSIZE (2048).
- NREQ, 4: number of write requesters, ≥2.
- DW, 32: data width.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  request a full-memory clear sweep; sampled in RUN only.
- req  in  NREQ  per-requester write valid.
- req_addr  in  NREQ*(BLOCKSIZE+1)  flattened addresses; requester i in slice i.
- req_din  in  NREQ*DW  flattened data; requester i in slice i.
- gnt  out  NREQ  one-hot grant (combinational), at most one bit set.
- busy  out  1  registered, high while in INIT (clear sweep).
- w1_addr  out  BLOCKSIZE+1  to memory write address, registered.
- w1_din  out  DW  to memory write data, registered.
- en_w1  out  1  to memory write enable, registered.

## Operation
- States: INIT (clear sweep), RUN (arbitrate).
- Registers: state, sweep counter cnt (BLOCKSIZE+1 bits), round-robin pointer ptr (clog2 NREQ bits), w1_addr, w1_din, en_w1.
- Reset values (every edge with rst=1): state=INIT, cnt=0, ptr=0, w1_addr=0, w1_din=0, en_w1=0, busy=1, gnt=0.
- INIT: each edge registers w1_addr=cnt, w1_din=0, en_w1=1, cnt=cnt+1. On the edge that issues cnt=DEPTH-1: state→RUN, busy→0, cnt→0 (wraps naturally). gnt=0 throughout INIT; req ignored; clr ignored.
- RUN, clr=1: gnt=0 that cycle; next edge state→INIT, busy→1, en_w1=0, cnt=0. clr beats any request in the same cycle. ptr unchanged.
- RUN, clr=0, some req set: winner = first i with req[i]=1 searching ptr, ptr+1, … wrapping mod NREQ. gnt[winner]=1. Next edge: w1_addr=req_addr[winner], w1_din=req_din[winner], en_w1=1, ptr=(winner+1) mod NREQ.
- RUN, no req: next edge en_w1=0; w1_addr/w1_din hold; ptr holds.
- Handshake: req/gnt is valid/ready. Requester holds req, addr, din stable until it sees gnt high. The transfer completes on the edge where req&gnt are both high. The requester may present a new write in the next cycle.
- Reset asserted mid-sweep or mid-RUN: next edge takes reset values. The sweep restarts from address 0 after release.

## Timing
- Grant to memory write: gnt in cycle N; en_w1/w1_addr/w1_din valid in cycle N+1; memory captures at end of N+1. Data is readable by read ports per memory latency thereafter.
- Sweep: first clear write presented on the first edge with rst=0. Exactly DEPTH consecutive en_w1=1 cycles follow, with addresses 0..DEPTH-1 ascending. busy falls on the same edge that presents address DEPTH-1.
- A grant in the first RUN cycle is written the cycle after address DEPTH-1. Ordering is preserved with no gap and no overlap.
- Throughput: one write per cycle sustained; with all req high, each requester is granted once every NREQ cycles.
- gnt depends combinationally on req, state, clr, ptr. There is no path from gnt back into req inside this block.

## Test plan
- Reset 3 cycles, then idle with req=0: en_w1=1 for exactly 2048 cycles with w1_addr 0..2047 and w1_din=0. busy drops with address 2047, then en_w1=0. The replicated memory model reads 0 on all 32 ports.
- RUN, req[2]=1 with addr 5, din 0xA5 for one cycle: gnt=4'b0100 that cycle. Next cycle en_w1=1, w1_addr=5, w1_din=0xA5. Reads of address 5 on all ports then return 0xA5.
- RUN, req=4'b1111 held, ptr=0: gnt sequence 0001, 0010, 0100, 1000, 0001… en_w1=1 every cycle with each requester's own address and data.
- req[1] held high through INIT: gnt=0 until busy falls. gnt[1]=1 in the first RUN cycle, and its write follows the address-2047 clear.
- RUN, clr=1 and req[3]=1 in the same cycle: gnt=0. The next cycle starts a sweep at address 0. req[3] is granted only after the 2048-cycle sweep completes.
- rst pulsed for one cycle when w1_addr=100 in INIT: en_w1=0 for that cycle, then the sweep restarts at address 0 and runs the full 2048 cycles.

Source files
------------

// File: rtl/rep_mem_write_sched.sv
// Write-port scheduler for the replicated-read memory: round-robin sharing of the
// single write port among NREQ requesters, plus a full-memory zero sweep after reset/clear.
module rep_mem_write_sched #(
  parameter int BLOCKSIZE = 10,
  parameter int NREQ      = 4,
  parameter int DW        = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic [NREQ-1:0]               req,
  input  logic [NREQ*(BLOCKSIZE+1)-1:0] req_addr,
  input  logic [NREQ*DW-1:0]            req_din,
  output logic [NREQ-1:0]               gnt,
  output logic                          busy,
  output logic [BLOCKSIZE:0]            w1_addr,
  output logic [DW-1:0]                 w1_din,
  output logic                          en_w1
);

  localparam int AW = BLOCKSIZE + 1;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {INIT, RUN} state_t;

  state_t         state;
  logic [AW-1:0]  cnt;
  logic [PW-1:0]  ptr;
  logic           found;
  logic [PW-1:0]  winner;
  logic [PW-1:0]  idx;
  logic [PW-1:0]  ptr_next;
  int             pos;
  int             nxt;

  // Search starts at ptr and wraps, so the last winner has lowest priority next time.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    pos      = 0;
    nxt      = 0;
    ptr_next = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = int'(ptr) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      idx = PW'(pos);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    nxt = int'(winner) + 1;
    if (nxt >= NREQ) ptr_next = '0;
    else             ptr_next = PW'(nxt);
  end

  always_comb begin
    gnt = '0;
    if (state == RUN && !clr && found) gnt[winner] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      cnt     <= '0;
      ptr     <= '0;
      w1_addr <= '0;
      w1_din  <= '0;
      en_w1   <= 1'b0;
      busy    <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          w1_addr <= cnt;
          w1_din  <= '0;
          en_w1   <= 1'b1;
          cnt     <= cnt + 1'b1;
          // The last address is all ones, so cnt wraps back to zero by itself.
          if (cnt == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          if (clr) begin
            state <= INIT;
            busy  <= 1'b1;
            en_w1 <= 1'b0;
            cnt   <= '0;
          end else if (found) begin
            w1_addr <= req_addr[int'(winner)*AW +: AW];
            w1_din  <= req_din[int'(winner)*DW +: DW];
            en_w1   <= 1'b1;
            ptr     <= ptr_next;
          end else begin
            en_w1 <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rep_mem_write_sched.sv
// Bench for rep_mem_write_sched: directed sweep/clear/reset scenarios plus random
// requester traffic, compared against a transaction-level model and a shadow memory.
module tb_rep_mem_write_sched;

  localparam int BLOCKSIZE = 10;
  localparam int NREQ      = 4;
  localparam int DW        = 32;
  localparam int AW        = BLOCKSIZE + 1;
  localparam int DEPTH     = 2 << BLOCKSIZE;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 clr;
  logic [NREQ-1:0]      req;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_din;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic [AW-1:0]        w1_addr;
  logic [DW-1:0]        w1_din;
  logic                 en_w1;

  int num_checks = 0;
  int num_fail   = 0;

  bit            m_sweep;
  int            m_cnt;
  int            m_ptr;
  bit            m_busy;
  bit            m_en;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  bit            pend  [NREQ];
  logic [AW-1:0] paddr [NREQ];
  logic [DW-1:0] pdin  [NREQ];

  logic [DW-1:0] exp_mem [DEPTH];
  logic [DW-1:0] act_mem [DEPTH];

  rep_mem_write_sched #(.BLOCKSIZE(BLOCKSIZE), .NREQ(NREQ), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .req      (req),
    .req_addr (req_addr),
    .req_din  (req_din),
    .gnt      (gnt),
    .busy     (busy),
    .w1_addr  (w1_addr),
    .w1_din   (w1_din),
    .en_w1    (en_w1)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Round robin from the spec: first pending requester at or after ptr, wrapping.
  function automatic int rrPick();
    for (int k = 0; k < NREQ; k++) begin
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic applyStimulus(input bit r, input bit c);
    int w;
    logic [NREQ-1:0] exp_gnt;
    @(negedge clk);
    rst = r;
    clr = c;
    for (int i = 0; i < NREQ; i++) begin
      req[i]              = pend[i];
      req_addr[i*AW +: AW] = paddr[i];
      req_din[i*DW +: DW]  = pdin[i];
    end
    w = (!r && !m_sweep && !c) ? rrPick() : -1;
    exp_gnt = '0;
    if (w >= 0) exp_gnt[w] = 1'b1;
    #1;
    if (!r) checkOutput("gnt", gnt, exp_gnt);
    if (r) begin
      m_sweep = 1; m_cnt = 0; m_ptr = 0; m_addr = '0; m_din = '0; m_en = 0; m_busy = 1;
    end else if (m_sweep) begin
      m_addr = AW'(m_cnt);
      m_din  = '0;
      m_en   = 1;
      m_cnt++;
      if (m_cnt == DEPTH) begin
        m_sweep = 0; m_busy = 0; m_cnt = 0;
      end
    end else if (c) begin
      m_sweep = 1; m_busy = 1; m_en = 0; m_cnt = 0;
    end else if (w >= 0) begin
      m_addr  = paddr[w];
      m_din   = pdin[w];
      m_en    = 1;
      m_ptr   = (w + 1) % NREQ;
      pend[w] = 0;
    end else begin
      m_en = 0;
    end
    if (m_en) exp_mem[m_addr] = m_din;
    @(posedge clk);
    #1;
    checkOutput("en_w1", en_w1, m_en);
    checkOutput("busy", busy, m_busy);
    if (r) checkOutput("rst_addr", w1_addr, 0);
    if (m_en) begin
      checkOutput("w1_addr", w1_addr, m_addr);
      checkOutput("w1_din", w1_din, m_din);
    end
    if (en_w1) act_mem[w1_addr] = w1_din;
  endtask

  task automatic newRequest(input int i);
    pend[i]  = 1;
    paddr[i] = AW'($urandom_range(0, DEPTH - 1));
    pdin[i]  = $urandom;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; req_addr = '0; req_din = '0;
    m_sweep = 1; m_cnt = 0; m_ptr = 0; m_busy = 1; m_en = 0; m_addr = '0; m_din = '0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; paddr[i] = '0; pdin[i] = '0;
    end
    for (int a = 0; a < DEPTH; a++) begin
      exp_mem[a] = 32'hDEAD_BEEF;
      act_mem[a] = 32'hDEAD_BEEF;
    end

    // Reset, then the power-on clear sweep and one idle cycle.
    repeat (3) applyStimulus(1, 0);
    repeat (DEPTH) applyStimulus(0, 0);
    applyStimulus(0, 0);
    for (int a = 0; a < DEPTH; a += 97) checkOutput("mem_clear", act_mem[a], 0);

    // Single write from requester 2.
    pend[2] = 1; paddr[2] = 11'd5; pdin[2] = 32'h0000_00A5;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("mem5", act_mem[5], 32'h0000_00A5);

    // All requesters held: one grant per cycle, rotating.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i]) newRequest(i);
      applyStimulus(0, 0);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    applyStimulus(0, 0);

    // clr beats a simultaneous request; requester 3 waits out the sweep.
    newRequest(3);
    applyStimulus(0, 1);
    repeat (DEPTH) applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("req3_served", pend[3], 0);

    // Requester 1 held through a sweep that is interrupted by reset at address 100.
    newRequest(1);
    applyStimulus(1, 0);
    for (int n = 0; n < 200 && !(m_en && m_addr == 11'd100); n++) applyStimulus(0, 0);
    checkOutput("reached_100", w1_addr, 100);
    applyStimulus(1, 0);
    repeat (DEPTH) applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("req1_served", pend[1], 0);

    // Random requester traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) if (!pend[i] && $urandom_range(0, 1) == 1) newRequest(i);
      applyStimulus(0, 0);
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    applyStimulus(0, 0);

    for (int a = 0; a < DEPTH; a++) checkOutput("mem_final", act_mem[a], exp_mem[a]);

    $display("%0d/%0d checks passed", num_checks - num_fail, num_checks);
    $finish;
  end

endmodule
